// File: rtl/char_stream_buffer.sv
// rtl/char_stream_buffer.sv - character buffer that serves one character per consumer request level
module char_stream_buffer #(
    parameter int CHAR_WIDTH  = 8,
    parameter int DEPTH       = 64,
    parameter int ADDR_WIDTH  = 6,
    parameter int STOP_ON_NUL = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  rewind,
    input  logic                  wr_en,
    input  logic [CHAR_WIDTH-1:0] wr_char,
    input  logic                  next_char,
    output logic [CHAR_WIDTH-1:0] char,
    output logic                  char_valid,
    output logic                  has_finished,
    output logic                  full,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   level
);
    typedef enum logic [1:0] {ARMED, SERVED, DONE} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [CHAR_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_cnt;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [CHAR_WIDTH-1:0] rd_data;
    state_t                state;
    state_t                state_nxt;
    logic                  do_write;
    logic                  do_serve;
    logic                  do_finish;

    assign full     = (wr_cnt == DEPTH_CNT);
    assign level    = wr_cnt - rd_ptr;
    assign rd_data  = mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign do_write = wr_en && !full && !clear && !rewind;

    // Reads compare against the pre-write wr_cnt, so a same-cycle write never feeds an empty request.
    always_comb begin
        state_nxt = state;
        do_serve  = 1'b0;
        do_finish = 1'b0;
        if (clear || rewind) begin
            state_nxt = ARMED;
        end else begin
            case (state)
                ARMED: begin
                    if (next_char) begin
                        if (rd_ptr < wr_cnt) begin
                            do_serve = 1'b1;
                            if ((STOP_ON_NUL != 0) && (rd_data == '0)) begin
                                do_finish = 1'b1;
                                state_nxt = DONE;
                            end else begin
                                state_nxt = SERVED;
                            end
                        end else begin
                            do_finish = 1'b1;
                            state_nxt = DONE;
                        end
                    end
                end
                SERVED: begin
                    if (!next_char) state_nxt = ARMED;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ARMED;
        else          state <= state_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt       <= '0;
            rd_ptr       <= '0;
            char         <= '0;
            char_valid   <= 1'b0;
            has_finished <= 1'b0;
            overflow     <= 1'b0;
        end else if (clear) begin
            wr_cnt       <= '0;
            rd_ptr       <= '0;
            char_valid   <= 1'b0;
            has_finished <= 1'b0;
            overflow     <= 1'b0;
        end else if (rewind) begin
            rd_ptr       <= '0;
            char_valid   <= 1'b0;
            has_finished <= 1'b0;
        end else begin
            char_valid <= do_serve;
            if (do_serve) begin
                char   <= rd_data;
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_finish) has_finished <= 1'b1;
            if (do_write)   wr_cnt   <= wr_cnt + 1'b1;
            else if (wr_en) overflow <= 1'b1;
        end
    end

    // Storage is deliberately not reset; pointers gate access to stale slots.
    always_ff @(posedge clock) begin
        if (do_write) mem[wr_cnt[ADDR_WIDTH-1:0]] <= wr_char;
    end
endmodule
